fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the instruction cache.
- Owns the architectural fetch PC and drives it to the cache. Consumes the cache's inst_valid/inst_comp/inst outputs each cycle.
- Advances the PC by 2 (compressed) or 4 (standard) per fetched instruction.
- Buffers fetched instructions in a small FIFO and presents them to decode over a valid/ready handshake; a redirect (branch/jump/trap) from later stages flushes the FIFO.

Parameters:
- RESET_PC, 64'h0000_0000_0000_1000, fetch PC value after reset.
- DEPTH, 2, FIFO entries (power of two, >=2).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- cache_pc  output  64  fetch address to instruction cache (= pc register).
- cache_inst_valid  input  1  cache has the instruction at cache_pc this cycle.
- cache_inst_comp  input  1  instruction at cache_pc is 16-bit compressed.
- cache_inst  input  32  instruction bits from cache.
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  64  new fetch address.
- out_valid  output  1  FIFO head valid to decode.
- out_ready  input  1  decode accepts head.
- out_pc  output  64  PC of head instruction.
- out_inst  output  32  head instruction; bits [31:16] zero when compressed.
- out_comp  output  1  head instruction is compressed.

Behaviour:
- Reset (async assert):
  - pc = RESET_PC; FIFO empty (rd_ptr = wr_ptr = 0, count = 0).
  - out_valid = 0; out_pc, out_inst, out_comp = 0.
  - cache_pc = RESET_PC.
- cache_pc is driven combinationally from the pc register. The cache answers in the same cycle (hit) or holds inst_valid = 0 while it fills.
- pop = out_valid & out_ready.
- push = cache_inst_valid & ~redirect_valid & (count < DEPTH | pop).
  - Push while full is permitted only with a simultaneous pop.
- On push:
  - Write entry {pc, cache_comp ? {16'b0, cache_inst[15:0]} : cache_inst, cache_comp} at wr_ptr.
  - wr_ptr++ (mod DEPTH).
  - pc <= pc + (cache_inst_comp ? 2 : 4), modulo 2^64; wrap from 64'hFFFF_FFFF_FFFF_FFFE+2 gives 0.
- No push (cache miss or FIFO full without pop): pc holds. The cache stays addressed at the same pc, so no instruction is lost or duplicated.
- On pop: rd_ptr++ (mod DEPTH).
- count:
  - +1 on push only; -1 on pop only; unchanged on push & pop.
  - Never exceeds DEPTH; never underflows.
- out_* reflect the FIFO head combinationally from storage.
  - out_valid = (count != 0).
  - Latency: an instruction hit at cycle N is visible on out_* at cycle N+1.
- redirect_valid (highest priority):
  - Next edge: pc <= {redirect_pc[63:1], 1'b0}; bit 0 is forced to 0.
  - FIFO flushed: count = 0, pointers = 0.
  - No push that cycle, regardless of cache_inst_valid.
  - A pop in the same cycle is ignored for count purposes (flush wins); decode treats the handshake as completed.
  - out_valid = 0 in cycle after redirect.
  - A redirect arriving while the cache is mid-fill is legal; the cache completes its fill, and fetch resumes at the new pc once hit.
  - Back-to-back redirects: the last one wins.
- out_ready with out_valid = 0: no effect.
- Stall-free sustained throughput: 1 instruction/cycle when cache hits and out_ready = 1.
- No combinational path from out_ready to cache_pc.
- Reset asserted mid-operation: all state returns to reset values immediately (async); in-flight FIFO contents are discarded.

Test Plan:
- Reset, cache hits standard insts 0x00000013 at 0x1000/0x1004/0x1008, out_ready = 1 -> cache_pc sequence 0x1000, 0x1004, 0x1008, 0x100C; out_pc 0x1000/0x1004/0x1008 one cycle later; out_comp = 0.
- Mixed widths: comp 0x0001 at 0x1000, standard 0x00A00093 at 0x1002, comp 0x4501 at 0x1006 -> pc 0x1002, 0x1006, 0x1008; out_inst 0x00000001, 0x00A00093, 0x00004501.
- out_ready = 0 with hits -> exactly 2 entries pushed (0x1000, 0x1004), then cache_pc holds 0x1008 and count = 2. Raise out_ready -> pops in order with no loss; push resumes the same cycle as the first pop.
- Miss: cache_inst_valid = 0 for 5 cycles at 0x1004 -> cache_pc holds 0x1004, FIFO drains to out_valid = 0. Hit resumes -> 0x1004 delivered once.
- Redirect with 2 entries queued, redirect_pc = 0x2003 -> next cycle out_valid = 0 and cache_pc = 0x2002. The first out_pc after the hit is 0x2002.
- Redirect asserted with cache_inst_valid = 1 and a simultaneous pop -> no push; count = 0 after the edge. Async rst_n pulse mid-stream -> pc = 0x1000 and out_valid = 0 immediately.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: cache address/response, redirect, and the
// decode valid/ready handshake. master = fetch side, slave = environment.
interface fetch_unit_if;
  logic [63:0] cache_pc;
  logic        cache_inst_valid;
  logic        cache_inst_comp;
  logic [31:0] cache_inst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_comp;

  modport master (
    output cache_pc,
    output out_valid,
    output out_pc,
    output out_inst,
    output out_comp,
    input  cache_inst_valid,
    input  cache_inst_comp,
    input  cache_inst,
    input  redirect_valid,
    input  redirect_pc,
    input  out_ready
  );

  modport slave (
    input  cache_pc,
    input  out_valid,
    input  out_pc,
    input  out_inst,
    input  out_comp,
    output cache_inst_valid,
    output cache_inst_comp,
    output cache_inst,
    output redirect_valid,
    output redirect_pc,
    output out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, pushes cache hits into a small FIFO.
// Ports: clk, rst_n (async low), bus (fetch_unit_if.master).
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_1000,
  parameter int          DEPTH    = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        comp;
  } ent_t;

  ent_t          mem_q [DEPTH];
  logic [63:0]   pc_q, pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          pop, push;
  ent_t          wr_ent;

  assign bus.cache_pc  = pc_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_pc    = mem_q[rd_ptr_q].pc;
  assign bus.out_inst  = mem_q[rd_ptr_q].inst;
  assign bus.out_comp  = mem_q[rd_ptr_q].comp;

  assign pop  = bus.out_valid & bus.out_ready;
  assign push = bus.cache_inst_valid
              & ~bus.redirect_valid
              & ((count_q < FULL) | pop);

  always_comb begin
    wr_ent.pc   = pc_q;
    wr_ent.comp = bus.cache_inst_comp;
    wr_ent.inst = bus.cache_inst_comp
                ? {16'b0, bus.cache_inst[15:0]}
                : bus.cache_inst;
  end

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.redirect_valid) begin
      // Flush wins over any same-cycle pop.
      pc_d     = bus.redirect_pc & ~64'd1;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        pc_d = pc_q + (bus.cache_inst_comp ? 64'd2 : 64'd4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= wr_ent;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit plus an async-reset sequence.
// Expected values are hand-computed per cycle.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic        comp;
    logic [31:0] inst;
    logic        redir;
    logic [63:0] rpc;
    logic        rdy;
    logic [63:0] e_cpc;
    logic        e_v;
    logic [63:0] e_opc;
    logic [31:0] e_inst;
    logic        e_comp;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp, input int idx);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic addv(
    input logic hit, input logic comp, input logic [31:0] inst,
    input logic redir, input logic [63:0] rpc, input logic rdy,
    input logic [63:0] e_cpc, input logic e_v,
    input logic [63:0] e_opc, input logic [31:0] e_inst,
    input logic e_comp);
    vec_t v;
    v.hit = hit; v.comp = comp; v.inst = inst;
    v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.e_cpc = e_cpc; v.e_v = e_v; v.e_opc = e_opc;
    v.e_inst = e_inst; v.e_comp = e_comp;
    vq.push_back(v);
  endtask

  task automatic drive(input logic hit, input logic comp,
                       input logic [31:0] inst, input logic redir,
                       input logic [63:0] rpc, input logic rdy);
    bus.cache_inst_valid = hit;
    bus.cache_inst_comp  = comp;
    bus.cache_inst       = inst;
    bus.redirect_valid   = redir;
    bus.redirect_pc      = rpc;
    bus.out_ready        = rdy;
  endtask

  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFE;

  initial begin
    // standard hits, full throughput
    addv(1,0,32'h13,0,0,1, 64'h1004,1,64'h1000,32'h13,0);
    addv(1,0,32'h13,0,0,1, 64'h1008,1,64'h1004,32'h13,0);
    addv(1,0,32'h13,0,0,1, 64'h100C,1,64'h1008,32'h13,0);
    addv(0,0,0,0,0,1,      64'h100C,0,0,0,0);
    addv(0,0,0,1,64'h1000,1, 64'h1000,0,0,0,0);
    // mixed widths, compressed upper bits must be zeroed
    addv(1,1,32'hDEAD0001,0,0,1,
         64'h1002,1,64'h1000,32'h1,1);
    addv(1,0,32'h00A00093,0,0,1,
         64'h1006,1,64'h1002,32'h00A00093,0);
    addv(1,1,32'h12344501,0,0,1,
         64'h1008,1,64'h1006,32'h4501,1);
    addv(0,0,0,0,0,1,      64'h1008,0,0,0,0);
    addv(0,0,0,1,64'h1000,1, 64'h1000,0,0,0,0);
    // backpressure: fill to DEPTH, hold, then drain
    addv(1,0,32'h13,0,0,0, 64'h1004,1,64'h1000,32'h13,0);
    addv(1,0,32'h00100093,0,0,0,
         64'h1008,1,64'h1000,32'h13,0);
    addv(1,0,32'h00200113,0,0,0,
         64'h1008,1,64'h1000,32'h13,0);
    addv(1,0,32'h00200113,0,0,0,
         64'h1008,1,64'h1000,32'h13,0);
    addv(1,0,32'h00200113,0,0,1,
         64'h100C,1,64'h1004,32'h00100093,0);
    addv(0,0,0,0,0,1, 64'h100C,1,64'h1008,32'h00200113,0);
    addv(0,0,0,0,0,1, 64'h100C,0,0,0,0);
    // miss for 5 cycles at 0x1004
    addv(0,0,0,1,64'h1000,1, 64'h1000,0,0,0,0);
    addv(1,0,32'h13,0,0,0, 64'h1004,1,64'h1000,32'h13,0);
    addv(0,0,0,0,0,0, 64'h1004,1,64'h1000,32'h13,0);
    addv(0,0,0,0,0,1, 64'h1004,0,0,0,0);
    addv(0,0,0,0,0,1, 64'h1004,0,0,0,0);
    addv(0,0,0,0,0,1, 64'h1004,0,0,0,0);
    addv(0,0,0,0,0,1, 64'h1004,0,0,0,0);
    addv(1,0,32'h00100093,0,0,0,
         64'h1008,1,64'h1004,32'h00100093,0);
    addv(0,0,0,0,0,1, 64'h1008,0,0,0,0);
    // redirect with two queued, hit and pop in same cycle
    addv(1,0,32'h00200113,0,0,0,
         64'h100C,1,64'h1008,32'h00200113,0);
    addv(1,0,32'h13,0,0,0,
         64'h1010,1,64'h1008,32'h00200113,0);
    addv(1,0,32'h13,1,64'h2003,1, 64'h2002,0,0,0,0);
    addv(0,0,0,0,0,1, 64'h2002,0,0,0,0);
    addv(1,1,32'h4501,0,0,0,
         64'h2004,1,64'h2002,32'h4501,1);
    // back-to-back redirects, last wins
    addv(0,0,0,1,64'h3000,0, 64'h3000,0,0,0,0);
    addv(1,0,32'h13,1,64'h4001,0, 64'h4000,0,0,0,0);
    addv(1,0,32'h13,0,0,1, 64'h4004,1,64'h4000,32'h13,0);
    // pc wrap at top of address space
    addv(0,0,0,1,TOP,1, TOP,0,0,0,0);
    addv(1,1,32'h1,0,0,0, 64'h0,1,TOP,32'h1,1);
    addv(1,0,32'h13,0,0,1, 64'h4,1,64'h0,32'h13,0);

    drive(0,0,0,0,0,0);
    #12;
    chk("rst_cache_pc", bus.cache_pc, 64'h1000, -1);
    chk("rst_valid", 64'(bus.out_valid), 64'h0, -1);
    chk("rst_out_pc", bus.out_pc, 64'h0, -1);
    chk("rst_out_inst", 64'(bus.out_inst), 64'h0, -1);
    chk("rst_out_comp", 64'(bus.out_comp), 64'h0, -1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].hit, vq[i].comp, vq[i].inst,
            vq[i].redir, vq[i].rpc, vq[i].rdy);
      @(posedge clk);
      #1;
      chk("cache_pc", bus.cache_pc, vq[i].e_cpc, i);
      chk("out_valid", 64'(bus.out_valid), 64'(vq[i].e_v), i);
      if (vq[i].e_v) begin
        chk("out_pc", bus.out_pc, vq[i].e_opc, i);
        chk("out_inst", 64'(bus.out_inst),
            64'(vq[i].e_inst), i);
        chk("out_comp", 64'(bus.out_comp),
            64'(vq[i].e_comp), i);
      end
    end

    // async reset mid-stream with entries queued
    drive(1,0,32'h13,0,0,0);
    @(posedge clk);
    #1;
    chk("pre_rst_pc", bus.cache_pc, 64'h8, 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cache_pc", bus.cache_pc, 64'h1000, 101);
    chk("arst_valid", 64'(bus.out_valid), 64'h0, 101);
    chk("arst_out_pc", bus.out_pc, 64'h0, 101);
    drive(1,0,32'h13,0,0,1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_pc", bus.cache_pc, 64'h1004, 102);
    chk("post_rst_valid", 64'(bus.out_valid), 64'h1, 102);
    chk("post_rst_out_pc", bus.out_pc, 64'h1000, 102);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
